// File: rtl/mips_mem_pkg.sv
// Shared definitions for the single-port main-memory path: default widths,
// arbiter state encoding and access-owner encoding.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Data wins a tie unless fetch has already been passed over the limit.
  function automatic owner_e arb_pick(input logic if_req, input logic d_req,
                                      input logic starved);
    if (d_req && !(if_req && starved)) return OWN_D;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one access at a time, with data priority and a fetch starvation guard.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              starved;
  owner_e            pick;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    starved     = (STARVE_LIMIT != 0) && (starve_q == SC_MAX);
    pick        = arb_pick(if_req, d_req, starved);

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d = pick;
          state_d = ISSUE;
          if (pick == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only grants that actually make fetch wait count toward starvation.
            if (if_req && (starve_q != SC_MAX)) starve_d = starve_q + SC_W'(1);
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LAT_INIT;
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_IF)  if_rdata_d = mem_rdata;
          else if (!mem_we_q)     d_rdata_d  = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: instance 0 (latency 1, starve limit 4) and
// instance 1 (latency 3, guard disabled) against a transaction-level memory model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, if_req, if_ready, d_req, d_we, d_ready, mem_en, mem_we, busy;
  logic [1:0][AW-1:0] if_addr, d_addr, mem_addr;
  logic [1:0][DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT0), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT1), .STARVE_LIMIT(0)) u_dut_b (
    .clk(clk), .reset(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] init_word(input int w);
    if (w == 16) return 32'h2008_000A;
    return 32'h5A00_0000 ^ (32'(w) * 32'h0001_0101);
  endfunction

  // Memory array: read data is only valid in the single cycle the latency names.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [DW-1:0] arr [128];
    bit            inited = 1'b0;
    int            cnt = 0;
    logic [6:0]    idx = '0;
    always @(posedge clk) begin
      if (!inited) begin
        for (int w = 0; w < 128; w++) arr[w] <= init_word(w);
        inited <= 1'b1;
      end
      if (mem_en[g]) begin
        if (mem_we[g]) arr[mem_addr[g][8:2]] <= mem_wdata[g];
        idx <= mem_addr[g][8:2];
        cnt <= lat_of(g);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
    assign mem_rdata[g] = (cnt == 1) ? arr[idx] : 32'hBAD0_BAD0;
  end

  // A requester must hold its request until it has seen ready.
  for (genvar g = 0; g < 2; g++) begin : g_proto
    logic pi = 1'b0, pir = 1'b0, pd = 1'b0, pdr = 1'b0, pr = 1'b1;
    always @(posedge clk) begin
      if (!rst[g] && !pr) begin
        assert (!(pi && !pir && !if_req[g] && !if_ready[g]))
          else $error("fetch request dropped before ready");
        assert (!(pd && !pdr && !d_req[g] && !d_ready[g]))
          else $error("data request dropped before ready");
      end
      pi <= if_req[g]; pir <= if_ready[g];
      pd <= d_req[g];  pdr <= d_ready[g];
      pr <= rst[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a word memory plus the last value a load returned.
  logic [31:0]        shadow [2][128];
  logic [1:0][31:0]   last_ld;
  logic [DW-1:0]      exp_if_q[$];
  logic [DW-1:0]      exp_d_q[$];
  bit                 order_q[$];
  int                 rdy_cyc_q[$];

  function automatic logic [31:0] model_issue(input int i, input bit is_d, input bit we,
                                              input logic [31:0] a, input logic [31:0] wd);
    if (!is_d) return shadow[i][a[8:2]];
    if (we) begin
      shadow[i][a[8:2]] = wd;
      return last_ld[i];
    end
    last_ld[i] = shadow[i][a[8:2]];
    return last_ld[i];
  endfunction

  // Scoreboard monitor for instance 0.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst[0]) begin
      if (if_ready[0] || d_ready[0]) check("ready_exclusive", 32'(if_ready[0] & d_ready[0]), 0);
      if (mem_en[0]) check("mem_en_gap", 32'(prev_en), 0);
      if (if_ready[0]) begin
        if (exp_if_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL if_ready_unexpected: ready with no pending fetch");
        end else check("if_rdata", if_rdata[0], exp_if_q.pop_front());
      end
      if (d_ready[0]) begin
        if (exp_d_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_ready_unexpected: ready with no pending data access");
        end else check("d_rdata", d_rdata[0], exp_d_q.pop_front());
      end
    end
    prev_en = mem_en[0];
  end

  task automatic do_reset(input int i);
    @(negedge clk);
    rst[i] = 1'b1; if_req[i] = 1'b0; d_req[i] = 1'b0; last_ld[i] = '0;
    if (i == 0) begin exp_if_q.delete(); exp_d_q.delete(); end
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check({tag, "_busy"},      32'(busy[i]), 0);
    check({tag, "_mem_en"},    32'(mem_en[i]), 0);
    check({tag, "_mem_we"},    32'(mem_we[i]), 0);
    check({tag, "_if_ready"},  32'(if_ready[i]), 0);
    check({tag, "_d_ready"},   32'(d_ready[i]), 0);
    check({tag, "_mem_addr"},  mem_addr[i], 0);
    check({tag, "_mem_wdata"}, mem_wdata[i], 0);
    check({tag, "_if_rdata"},  if_rdata[i], 0);
    check({tag, "_d_rdata"},   d_rdata[i], 0);
  endtask

  // One isolated access from an idle arbiter, with timing checks.
  task automatic txn(input int i, input bit is_d, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    logic [31:0] exp;
    int en_k = 0, en_n = 0, rdy_k = 0;
    bit other = 1'b0;
    @(negedge clk);
    if (is_d) begin
      d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd; d_req[i] = 1'b1;
    end else begin
      if_addr[i] = a; if_req[i] = 1'b1;
    end
    exp = model_issue(i, is_d, we, a, wd);
    if (i == 0) begin
      if (is_d) exp_d_q.push_back(exp); else exp_if_q.push_back(exp);
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mem_en[i]) begin
        en_n++;
        if (en_k == 0) begin
          en_k = k;
          check({tag, "_mem_we"},   32'(mem_we[i]), 32'(is_d && we));
          check({tag, "_mem_addr"}, mem_addr[i], a);
          if (is_d && we) check({tag, "_mem_wdata"}, mem_wdata[i], wd);
        end
      end
      if (is_d ? if_ready[i] : d_ready[i]) other = 1'b1;
      if (is_d ? d_ready[i] : if_ready[i]) begin rdy_k = k; break; end
    end
    if (is_d) d_req[i] = 1'b0; else if_req[i] = 1'b0;
    check({tag, "_ready_lat"}, rdy_k, lat_of(i) + 2);
    check({tag, "_en_at"},     en_k, 1);
    check({tag, "_en_count"},  en_n, 1);
    check({tag, "_other_rdy"}, 32'(other), 0);
    if (i == 1) check({tag, "_rdata"}, is_d ? d_rdata[1] : if_rdata[1], exp);
  endtask

  // A stream of n requests on one port; gap 0 keeps the request line high.
  task automatic port_seq(input int i, input bit is_d, input int n, input int gap_max,
                          input bit rnd_we);
    logic [31:0] a, wd, exp;
    bit we, got;
    int gap;
    for (int t = 0; t < n; t++) begin
      gap = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
      if (gap > 0) begin
        if (is_d) d_req[i] = 1'b0; else if_req[i] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      wd = $urandom;
      we = is_d && rnd_we && ($urandom_range(1, 0) == 1);
      if (is_d) begin
        a = 32'h100 + ($urandom_range(63, 0) << 2);
        d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd; d_req[i] = 1'b1;
      end else begin
        a = $urandom_range(63, 0) << 2;
        if_addr[i] = a; if_req[i] = 1'b1;
      end
      exp = model_issue(i, is_d, we, a, wd);
      if (i == 0) begin
        if (is_d) exp_d_q.push_back(exp); else exp_if_q.push_back(exp);
      end
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        got = is_d ? d_ready[i] : if_ready[i];
      end
      check(is_d ? "seq_d_done" : "seq_if_done", 32'(got), 1);
      if (got) begin
        order_q.push_back(is_d);
        rdy_cyc_q.push_back(cyc);
        if (i == 1) check("b_seq_rdata", is_d ? d_rdata[1] : if_rdata[1], exp);
      end
    end
    if (is_d) d_req[i] = 1'b0; else if_req[i] = 1'b0;
  endtask

  function automatic logic [15:0] order_vec();
    logic [15:0] v = '0;
    foreach (order_q[j]) if (j < 16) v[j] = order_q[j];
    return v;
  endfunction

  task automatic clear_order();
    order_q.delete();
    rdy_cyc_q.delete();
  endtask

  initial begin
    rst = 2'b11; if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; last_ld = '0;
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 128; w++) shadow[i][w] = init_word(w);
    repeat (3) @(negedge clk);
    check_reset_vals(0, "a_rst");
    check_reset_vals(1, "b_rst");
    rst = 2'b00;

    // Instance 0: directed fetch, store then load.
    txn(0, 1'b0, 1'b0, 32'h40,  32'h0,         "a_fetch40");
    txn(0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, "a_store100");
    txn(0, 1'b1, 1'b0, 32'h100, 32'h0,         "a_load100");

    // Simultaneous requests: data first, fetch one access period later.
    do_reset(0);
    clear_order();
    fork
      port_seq(0, 1'b0, 1, 0, 1'b0);
      port_seq(0, 1'b1, 1, 0, 1'b0);
    join
    check("a_tie_count", order_q.size(), 2);
    check("a_tie_order", order_vec(), 16'h0001);
    if (rdy_cyc_q.size() == 2) check("a_tie_gap", rdy_cyc_q[1] - rdy_cyc_q[0], LAT0 + 3);

    // Both continuously requesting: D,D,D,D,IF,D,D,D,D,IF.
    do_reset(0);
    clear_order();
    fork
      port_seq(0, 1'b0, 2, 0, 1'b0);
      port_seq(0, 1'b1, 8, 0, 1'b0);
    join
    check("a_starve_count", order_q.size(), 10);
    check("a_starve_order", order_vec(), 16'h01EF);

    // Random traffic on both ports.
    @(negedge clk);
    fork
      port_seq(0, 1'b0, 40, 3, 1'b0);
      port_seq(0, 1'b1, 40, 3, 1'b1);
    join
    repeat (6) @(negedge clk);
    check("a_sb_if_drain", exp_if_q.size(), 0);
    check("a_sb_d_drain",  exp_d_q.size(), 0);

    // Instance 1: latency 3 accesses.
    txn(1, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D, "b_store104");
    txn(1, 1'b1, 1'b0, 32'h104, 32'h0,         "b_load104");
    txn(1, 1'b0, 1'b0, 32'h40,  32'h0,         "b_fetch40");

    // Guard disabled: fetch only completes once data stops asking.
    do_reset(1);
    clear_order();
    fork
      port_seq(1, 1'b0, 1, 0, 1'b0);
      port_seq(1, 1'b1, 6, 0, 1'b0);
    join
    check("b_nostarve_count", order_q.size(), 7);
    check("b_nostarve_order", order_vec(), 16'h003F);

    // Reset while waiting on memory abandons the access.
    txn(1, 1'b1, 1'b1, 32'h108, 32'h1234_5678, "b_store108");
    @(negedge clk);
    if_addr[1] = 32'h80; if_req[1] = 1'b1;
    @(negedge clk);
    check("b_wr_issue", 32'(mem_en[1]), 1);
    @(negedge clk);
    check("b_wr_wait_busy", 32'(busy[1]), 1);
    rst[1] = 1'b1; if_req[1] = 1'b0; last_ld[1] = '0;
    @(negedge clk);
    check_reset_vals(1, "b_wr");
    rst[1] = 1'b0;
    begin
      int rdy_n = 0;
      repeat (6) begin
        @(negedge clk);
        if (if_ready[1] || d_ready[1] || busy[1]) rdy_n++;
      end
      check("b_wr_quiet", rdy_n, 0);
    end
    txn(1, 1'b0, 1'b0, 32'h44, 32'h0, "b_fresh44");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: run did not reach its end, got cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port main memory between the instruction-fetch path and the load/store (data) path. Each requester holds a request until it receives a one-cycle ready pulse. The arbiter sequences one memory access at a time with a fixed memory read latency. Data accesses have priority, and a starvation guard guarantees forward progress for fetch. It sits between the CPU datapath and the main-memory array.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- MEM_LATENCY, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid (≥1)
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win; 0 disables the guard
- clk  in  1  system clock; rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_ready  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready, held afterwards
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  DATA_W  load data; updated only by loads
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  access address (held for the whole access)
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration at each edge:
  - If only one request is high, that requester wins.
  - If both are high, data wins unless STARVE_LIMIT≠0 and starve_cnt==STARVE_LIMIT; in that case fetch wins.
  - The winner's addr, we and wdata are latched into mem_* registers. Fetch always has we=0.
  - Next state is ISSUE.
- ISSUE: mem_en=1 for exactly this cycle. Next state is WAIT, with the latency counter loaded to MEM_LATENCY.
- WAIT: the counter decrements each cycle. In the cycle where mem_rdata is valid (MEM_LATENCY cycles after ISSUE), the arbiter registers mem_rdata into the owner's rdata (reads only) and moves to RESP.
- RESP: the owner's ready is 1 for one cycle. Requests are ignored here, because the owner's req is still high for the completed access. Next state is IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - Clears on every fetch grant.
  - Holds otherwise.
- A request deasserted before ready is a protocol violation. Behaviour is undefined; the bench checks for it with an assertion.

## Timing
- Request sampled at edge T0. mem_en is high in cycle T0+1. Ready is high in cycle T0+MEM_LATENCY+2.
- Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- Reset values:
  - state IDLE; mem_en, mem_we, if_ready, d_ready, busy = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - starve_cnt = 0.
- Reset mid-access abandons the access. No ready is issued, and the next cycle is IDLE.
- A request that rises while the arbiter is busy waits until IDLE. There is no queueing beyond the held request.
- if_ready and d_ready are never high in the same cycle.
- mem_en is never high in two consecutive cycles.

## Structure
- Package mips_mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The arbiter state enum (IDLE/ISSUE/WAIT/RESP).
  - The owner encoding (OWN_IF=0, OWN_D=1).
- Shared with the CPU top and the memory model.
- No sub-module: the latency counter and starve counter stay inline. This is a single always block for state and registers, plus one combinational block for arbitration.

## Test plan
- Single fetch, MEM_LATENCY=1, if_addr=0x40, memory[0x40]=0x2008000A:
  - mem_en pulses at T0+1.
  - if_ready at T0+3 with if_rdata=0x2008000A.
  - d_ready stays 0.
- Store then load, d_addr=0x100:
  - Store 0xDEADBEEF: mem_we=1 during ISSUE; d_ready pulses; d_rdata unchanged.
  - Load 0x100: d_rdata=0xDEADBEEF.
- Simultaneous if_req and d_req from IDLE: data is granted first; fetch completes MEM_LATENCY+3 cycles later.
- Both requesters continuously requesting, STARVE_LIMIT=4:
  - Grant order is D,D,D,D,IF,D,D,D,D,IF.
  - With STARVE_LIMIT=0, fetch never completes while d_req stays high.
- MEM_LATENCY=3: ready appears exactly 5 cycles after the request edge, and mem_en lasts exactly 1 cycle.
- Reset asserted in WAIT:
  - The following cycle has busy=0, no ready pulse, and all outputs at their reset values.
  - A fresh request after reset completes normally.
